// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: opcodes, execute-stage FSM states, default widths.
// No logic; latency n/a.
// Backpressure n/a.
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 3;
    localparam int CNT_W      = 6;
    localparam logic [CNT_W-1:0] MUL_STEPS = 6'd32;

    typedef enum logic [2:0] {
        OP_MOV = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_MUL = 3'b101,
        OP_SLL = 3'b110,
        OP_SRA = 3'b111
    } opcode_e;

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_e;

    // Shifts by zero collapse to a move of OPERAND1, so only MUL and nonzero shifts iterate.
    function automatic logic needs_iter(input opcode_e op, input logic [4:0] amt);
        return (op == OP_MUL) || (((op == OP_SLL) || (op == OP_SRA)) && (amt != 5'd0));
    endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Issue and writeback signals between register file read, execute stage and register file write.
// Wires only; latency n/a.
// Upstream holds its issue fields until IN_VALID && IN_READY.
interface alu_exec_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic              IN_VALID;
    logic              IN_READY;
    logic [2:0]        OPCODE;
    logic [DATA_W-1:0] OPERAND1;
    logic [DATA_W-1:0] OPERAND2;
    logic [ADDR_W-1:0] DEST;
    logic              WB_EN;
    logic [DATA_W-1:0] RESULT;
    logic [ADDR_W-1:0] RESULT_ADDR;
    logic              RESULT_WRITE;
    logic              ZERO;
    logic              BUSY;

    modport master (
        output IN_VALID, OPCODE, OPERAND1, OPERAND2, DEST, WB_EN,
        input  IN_READY, RESULT, RESULT_ADDR, RESULT_WRITE, ZERO, BUSY
    );

    modport slave (
        input  IN_VALID, OPCODE, OPERAND1, OPERAND2, DEST, WB_EN,
        output IN_READY, RESULT, RESULT_ADDR, RESULT_WRITE, ZERO, BUSY
    );
endinterface

// File: rtl/alu_iter_unit.sv
// Bit-serial engine for MUL (32-step shift-add) and SLL/SRA (one bit per step).
// Latency: 32 steps for MUL, shift-amount steps for shifts; done flags the final step.
// No backpressure; caller loads only when idle.
module alu_iter_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              load,
    input  opcode_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] value
);

    opcode_e           op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] acc_q, opnd_q, mplr_q;
    logic [DATA_W-1:0] acc_n, opnd_n, mplr_n;

    // opnd doubles as multiplicand (shifted left each step) and shift operand.
    always_comb begin
        acc_n = acc_q;
        if ((op_q == OP_MUL) && mplr_q[0]) begin
            acc_n = acc_q + opnd_q;
        end
        opnd_n = (op_q == OP_SRA) ? {opnd_q[DATA_W-1], opnd_q[DATA_W-1:1]} : (opnd_q << 1);
        mplr_n = mplr_q >> 1;
    end

    assign done  = (cnt_q == 6'd1);
    assign value = (op_q == OP_MUL) ? acc_n : opnd_n;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            op_q   <= OP_MOV;
            cnt_q  <= '0;
            acc_q  <= '0;
            opnd_q <= '0;
            mplr_q <= '0;
        end else if (load) begin
            op_q   <= op;
            cnt_q  <= (op == OP_MUL) ? MUL_STEPS : {1'b0, b[4:0]};
            acc_q  <= '0;
            opnd_q <= a;
            mplr_q <= b;
        end else if (cnt_q != '0) begin
            cnt_q  <= cnt_q - 6'd1;
            acc_q  <= acc_n;
            opnd_q <= opnd_n;
            mplr_q <= mplr_n;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// CPU execute stage: single-cycle ALU plus iterative MUL/SLL/SRA, registered writeback to the regfile.
// Latency: 1 cycle for simple ops, k+1 for shift by k, 33 for MUL.
// IN_READY only in IDLE; requests while busy are ignored, not queued.
module alu_exec
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic       CLK,
    input  logic       RESET,
    alu_exec_if.slave  bus
);

    state_e            state;
    opcode_e           op;
    logic              accept;
    logic              go_iter;
    logic              iter_done;
    logic [DATA_W-1:0] iter_val;
    logic [DATA_W-1:0] alu_val;
    logic [DATA_W-1:0] result_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] dest_q;
    logic              write_q;
    logic              zero_q;
    logic              wb_q;

    assign op           = opcode_e'(bus.OPCODE);
    assign bus.IN_READY = (state == IDLE) && !RESET;
    assign accept       = bus.IN_VALID && bus.IN_READY;
    assign go_iter      = needs_iter(op, bus.OPERAND2[4:0]);

    assign bus.RESULT       = result_q;
    assign bus.RESULT_ADDR  = addr_q;
    assign bus.RESULT_WRITE = write_q;
    assign bus.ZERO         = zero_q;
    assign bus.BUSY         = (state == ITER);

    // Shift opcodes only reach this path with a zero amount.
    always_comb begin
        alu_val = '0;
        case (op)
            OP_MOV:          alu_val = bus.OPERAND2;
            OP_ADD:          alu_val = bus.OPERAND1 + bus.OPERAND2;
            OP_SUB:          alu_val = bus.OPERAND1 - bus.OPERAND2;
            OP_AND:          alu_val = bus.OPERAND1 & bus.OPERAND2;
            OP_OR:           alu_val = bus.OPERAND1 | bus.OPERAND2;
            OP_SLL, OP_SRA:  alu_val = bus.OPERAND1;
            default:         alu_val = '0;
        endcase
    end

    alu_iter_unit #(.DATA_W(DATA_W)) u_iter (
        .CLK   (CLK),
        .RESET (RESET),
        .load  (accept && go_iter),
        .op    (op),
        .a     (bus.OPERAND1),
        .b     (bus.OPERAND2),
        .done  (iter_done),
        .value (iter_val)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            result_q <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            zero_q   <= 1'b1;
            dest_q   <= '0;
            wb_q     <= 1'b0;
        end else begin
            write_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (go_iter) begin
                            state  <= ITER;
                            dest_q <= bus.DEST;
                            wb_q   <= bus.WB_EN;
                        end else begin
                            result_q <= alu_val;
                            addr_q   <= bus.DEST;
                            zero_q   <= (alu_val == '0);
                            write_q  <= bus.WB_EN;
                        end
                    end
                end
                ITER: begin
                    if (iter_done) begin
                        state    <= IDLE;
                        result_q <= iter_val;
                        addr_q   <= dest_q;
                        zero_q   <= (iter_val == '0);
                        write_q  <= wb_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: driver pushes reference results with expected write cycle,
// a negedge monitor pops and compares on every RESULT_WRITE.
module tb_alu_exec;
    import cpu_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  addr;
        int          cyc;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    alu_exec_if #(.DATA_W(32), .ADDR_W(3)) bus ();

    alu_exec #(.DATA_W(32), .ADDR_W(3)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    exp_t sbq[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   wr_cnt = 0;
    int   c1, c2, w1, w2, b1, b2, snap, guard;
    logic [31:0] ra, rb;
    logic [2:0]  rop, rd;
    logic        rwb;

    always @(negedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (op)
            3'd0: return b;
            3'd1: return a + b;
            3'd2: return a - b;
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: begin
                p = {32'd0, a} * {32'd0, b};
                return p[31:0];
            end
            3'd6: return a << b[4:0];
            default: return $unsigned($signed(a) >>> b[4:0]);
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] b);
        if (op == 3'd5) return 32;
        if (op == 3'd6 || op == 3'd7) return int'(b[4:0]);
        return 0;
    endfunction

    // Monitor: every write strobe must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (bus.RESULT_WRITE === 1'b1) begin
            wr_cnt++;
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got write of 0x%08h to r%0d at cycle %0d, expected none",
                         bus.RESULT, bus.RESULT_ADDR, cyc);
            end else begin
                e = sbq.pop_front();
                chk("result", bus.RESULT, e.res);
                chk("result_addr", {29'd0, bus.RESULT_ADDR}, {29'd0, e.addr});
                chk("zero", {31'd0, bus.ZERO}, {31'd0, (e.res == 32'd0)});
                chk("write_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] d, input logic wb,
                         output int acc_cyc, output int waited, output int busy_n);
        exp_t e;
        waited  = 0;
        busy_n  = 0;
        acc_cyc = -1;
        @(negedge CLK);
        bus.OPCODE   = op;
        bus.OPERAND1 = a;
        bus.OPERAND2 = b;
        bus.DEST     = d;
        bus.WB_EN    = wb;
        bus.IN_VALID = 1'b1;
        while (bus.IN_READY !== 1'b1) begin
            if (bus.BUSY === 1'b1) busy_n++;
            waited++;
            if (waited > 60) begin
                n_vec++;
                n_err++;
                $display("FAIL accept_timeout: got no IN_READY in %0d cycles, expected accept", waited);
                bus.IN_VALID = 1'b0;
                return;
            end
            @(negedge CLK);
        end
        acc_cyc = cyc;
        if (wb) begin
            e.res  = ref_res(op, a, b);
            e.addr = d;
            e.cyc  = cyc + 1 + ref_lat(op, b);
            sbq.push_back(e);
        end
        @(posedge CLK);
        #1 bus.IN_VALID = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET        = 1'b1;
        bus.IN_VALID = 1'b0;
        bus.OPCODE   = 3'd0;
        bus.OPERAND1 = '0;
        bus.OPERAND2 = '0;
        bus.DEST     = '0;
        bus.WB_EN    = 1'b0;
        #12;
        chk("rst_result", bus.RESULT, 32'd0);
        chk("rst_addr", {29'd0, bus.RESULT_ADDR}, 32'd0);
        chk("rst_write", {31'd0, bus.RESULT_WRITE}, 32'd0);
        chk("rst_zero", {31'd0, bus.ZERO}, 32'd1);
        chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        #1 chk("rst_ready", {31'd0, bus.IN_READY}, 32'd1);

        issue(3'd1, 32'h7FFF_FFFF, 32'h0000_0001, 3'd5, 1'b1, c1, w1, b1);

        // back-to-back single-cycle ops at full rate
        issue(3'd2, 32'd3, 32'd3, 3'd1, 1'b1, c1, w1, b1);
        issue(3'd0, 32'h1111_1111, 32'hDEAD_BEEF, 3'd2, 1'b1, c2, w2, b2);
        chk("b2b_gap", 32'(c2 - c1), 32'd1);

        // SRA by 4 with a follower held during the busy window
        issue(3'd7, 32'h8000_0000, 32'hFFFF_FFE4, 3'd6, 1'b1, c1, w1, b1);
        issue(3'd1, 32'd1, 32'd2, 3'd3, 1'b1, c2, w2, b2);
        chk("sra_accept_gap", 32'(c2 - c1), 32'd5);
        chk("sra_ready_low", 32'(w2), 32'd4);
        chk("sra_busy_cycles", 32'(b2), 32'd4);

        issue(3'd5, 32'h0001_0001, 32'h0001_0001, 3'd4, 1'b1, c1, w1, b1);
        issue(3'd5, 32'h0000_0000, 32'h1234_5678, 3'd7, 1'b1, c1, w1, b1);
        issue(3'd4, 32'h00F0_0000, 32'h0000_000F, 3'd2, 1'b1, c2, w2, b2);
        chk("mul_zero_issue_gap", 32'(c2 - c1), 32'd33);

        // MUL without write-back: state updates, no strobe
        repeat (3) @(negedge CLK);
        snap = wr_cnt;
        issue(3'd5, 32'h0000_1234, 32'h0000_5678, 3'd3, 1'b0, c1, w1, b1);
        guard = 0;
        @(negedge CLK);
        while (bus.IN_READY !== 1'b1 && guard < 60) begin
            guard++;
            @(negedge CLK);
        end
        chk("nowb_result", bus.RESULT, 32'h0000_1234 * 32'h0000_5678);
        chk("nowb_addr", {29'd0, bus.RESULT_ADDR}, 32'd3);
        chk("nowb_zero", {31'd0, bus.ZERO}, 32'd0);
        chk("nowb_writes", 32'(wr_cnt - snap), 32'd0);

        // SLL by zero amount, upper OPERAND2 bits ignored
        issue(3'd6, 32'hCAFE_F00D, 32'h0000_0020, 3'd1, 1'b1, c1, w1, b1);
        repeat (2) @(negedge CLK);

        // reset in the middle of a MUL
        issue(3'd5, 32'h0000_FFFF, 32'h0000_FFFF, 3'd6, 1'b1, c1, w1, b1);
        repeat (10) @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("abort_result", bus.RESULT, 32'd0);
        chk("abort_addr", {29'd0, bus.RESULT_ADDR}, 32'd0);
        chk("abort_write", {31'd0, bus.RESULT_WRITE}, 32'd0);
        chk("abort_zero", {31'd0, bus.ZERO}, 32'd1);
        chk("abort_busy", {31'd0, bus.BUSY}, 32'd0);
        sbq.delete();
        @(negedge CLK);
        RESET = 1'b0;
        #1 chk("abort_ready", {31'd0, bus.IN_READY}, 32'd1);
        snap = wr_cnt;
        repeat (40) @(negedge CLK);
        chk("abort_no_write", 32'(wr_cnt - snap), 32'd0);

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) rb = ra;
            rd  = 3'($urandom_range(0, 7));
            rwb = ($urandom_range(0, 3) != 0);
            issue(rop, ra, rb, rd, rwb, c1, w1, b1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
        end

        guard = 0;
        while (sbq.size() != 0 && guard < 100) begin
            guard++;
            @(negedge CLK);
        end
        chk("drain_pending", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute stage of the CPU datapath, directly downstream of the 8×32 register file. Takes the two read operands, a 3-bit opcode and a destination address, and computes the result. Single-cycle ops finish in one cycle; MUL and shifts run iteratively, one bit per cycle. The result is then driven back as the register file's write data, write address and write strobe.

## Interface
Parameters:
- DATA_W, 32, operand/result width (MUL and shift counts defined for 32)
- ADDR_W, 3, register address width

Ports:
- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  asynchronous, active-high; clears all state immediately
- IN_VALID  in  1  operation presented this cycle
- IN_READY  out  1  stage can accept; combinational, high only in IDLE
- OPCODE  in  3  000 MOV, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 MUL, 110 SLL, 111 SRA
- OPERAND1  in  DATA_W  first source (register file OUT1)
- OPERAND2  in  DATA_W  second source / shift amount (register file OUT2)
- DEST  in  ADDR_W  destination register
- WB_EN  in  1  write back result
- RESULT  out  DATA_W  registered result; feeds register file IN
- RESULT_ADDR  out  ADDR_W  registered destination; feeds WRADDRESS
- RESULT_WRITE  out  1  one-cycle write strobe; feeds WRITE
- ZERO  out  1  registered, RESULT == 0, updated with RESULT
- BUSY  out  1  high in ITER

## Operation
- Accept: IN_VALID && IN_READY at a posedge (edge E0) latches OPCODE, operands, DEST, WB_EN.
- FSM states:
  - IDLE → IDLE for single-cycle ops.
  - IDLE → ITER for MUL, and for SLL/SRA with OPERAND2[4:0] ≠ 0.
  - ITER → IDLE on the edge performing the final step.
- MOV: RESULT = OPERAND2.
- ADD/SUB: modulo 2^32; carry and borrow are dropped.
- AND/OR: bitwise.
- SLL/SRA: shift OPERAND1 by OPERAND2[4:0]; OPERAND2[31:5] is ignored. SRA replicates bit 31. A shift by 0 is a single-cycle op with RESULT = OPERAND1.
- MUL:
  - Unsigned shift-add over 32 steps; RESULT = low 32 bits of the product.
  - Step count is always 32, including when either operand is 0.
- Iteration counter:
  - Loaded at E0 with 32 (MUL) or the shift amount.
  - Each ITER edge performs one step and decrements the counter.
- Completion edge: RESULT, RESULT_ADDR and ZERO update. RESULT_WRITE = latched WB_EN for exactly one cycle.
- WB_EN = 0: RESULT, RESULT_ADDR and ZERO still update; RESULT_WRITE stays 0.
- RESULT, RESULT_ADDR and ZERO hold until the next completion.
- IN_VALID while not ready: ignored, not queued. The upstream stage holds its inputs until accepted.
- RESET mid-ITER: the operation is aborted, no write is issued, FSM returns to IDLE.

## Timing
- Reset values: RESULT = 0, RESULT_ADDR = 0, RESULT_WRITE = 0, ZERO = 1, BUSY = 0, state IDLE, counter 0. IN_READY = 1 once RESET deasserts.
- Single-cycle op accepted at E0: RESULT_WRITE high in the cycle after E0. Back-to-back accepts are allowed at full rate (one per cycle).
- Shift by k (1..31): IN_READY low for k cycles. RESULT_WRITE high in the cycle after edge E0+k. The next accept is possible at E0+k+1.
- MUL: as a shift with k = 32, giving a 33-cycle issue interval.
- Read-after-write: the register file writes on the edge after RESULT_WRITE rises. An op depending on DEST may be accepted at the earliest one edge after that write. Enforcing this spacing is the upstream stage's responsibility.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants OP_MOV..OP_SRA
  - FSM state encoding (IDLE, ITER)
  - DATA_W/ADDR_W defaults
- Sub-module `alu_iter_unit`:
  - owns the accumulator, shifted operand and counter for MUL/SLL/SRA
  - inputs: load, op, operands; outputs: done, value
- Top level: FSM, handshake, single-cycle ALU, output registers.

## Test plan
- Reset, then ADD 0x7FFFFFFF + 0x00000001, DEST 5, WB_EN 1 → next cycle RESULT 0x80000000, RESULT_ADDR 5, RESULT_WRITE 1 for one cycle, ZERO 0.
- SUB 3 − 3, then back-to-back MOV 0xDEADBEEF (DEST 2) → RESULT_WRITE high two consecutive cycles; first RESULT 0 with ZERO 1, then 0xDEADBEEF with RESULT_ADDR 2.
- SRA 0x80000000 by OPERAND2 0xFFFFFFE4 (amount 4) → IN_READY low 4 cycles, BUSY high 4 cycles; RESULT 0xF8000000 after edge E0+4. An IN_VALID held during busy is accepted only at E0+5.
- MUL 0x00010001 × 0x00010001 → RESULT_WRITE after edge E0+32, RESULT 0x00020001. Repeat with OPERAND1 0 → still 32 cycles, RESULT 0, ZERO 1.
- MUL with WB_EN 0 → RESULT updates, RESULT_WRITE never asserts.
- SLL by 0 → single-cycle, RESULT = OPERAND1. Start MUL, assert RESET at step 10 → all outputs at reset values immediately, no RESULT_WRITE afterwards, IN_READY 1 after RESET deasserts.
